// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows stage for NB = 4, 6 or 8 columns.
// The transform is applied on the way in; a 2-entry output/skid buffer decouples both handshakes.
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [32*NB-1:0]     in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*NB-1:0]     out_data,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $fatal(1, "shift_rows_pipe: TAG_W must be at least 1");
        end
    endgenerate

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Buffer occupancy; kept as a named register so checkers can bind to it.
    logic [1:0]       state;
    logic [W-1:0]     skid_data;
    logic [TAG_W-1:0] skid_tag;
    logic [W-1:0]     xf_data;
    logic             accept;
    logic             consume;

    // Rijndael row shift amounts: the 256-bit block uses a wider spread on rows 2 and 3.
    function automatic int row_off(input int r);
        int off;
        off = r;
        if (NB == 8 && r >= 2) begin
            off = r + 1;
        end
        return off;
    endfunction

    // Byte r+4c sits at bits [W-1-8(r+4c) -: 8]; forward rotates each row left by its
    // offset, inverse rotates it right, so row 0 passes through unchanged in both modes.
    always_comb begin
        xf_data = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                if (in_mode) begin
                    xf_data[W-1-8*(r+4*c) -: 8] =
                        in_data[W-1-8*(r+4*((c + NB - row_off(r)) % NB)) -: 8];
                end else begin
                    xf_data[W-1-8*(r+4*c) -: 8] =
                        in_data[W-1-8*(r+4*((c + row_off(r)) % NB)) -: 8];
                end
            end
        end
    end

    // Handshake: a beat moves on a port only in a cycle where its valid and ready are both
    // high at the rising edge; in_ready and out_valid are pure decodes of the state register,
    // so neither depends combinationally on in_valid or out_ready.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state == ST_ONE) || (state == ST_FULL);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_data  <= '0;
            out_tag   <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_data <= xf_data;
                        out_tag  <= in_tag;
                        state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        out_data <= xf_data;
                        out_tag  <= in_tag;
                    end else if (accept) begin
                        skid_data <= xf_data;
                        skid_tag  <= in_tag;
                        state     <= ST_FULL;
                    end else if (consume) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        out_data <= skid_data;
                        out_tag  <= skid_tag;
                        state    <= ST_ONE;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    // A stalled output beat must not change underneath the consumer.
    out_hold_stable: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag))
    );

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: directed vectors for NB=4/6/8, backpressure, random streaming
// against a row-rotation reference model, and asynchronous reset while full.
module tb_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_mode = 1'b0;
    logic [127:0] in_data = '0;
    logic [3:0]   in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [3:0]   out_tag;

    logic         v6_in_valid = 1'b0;
    logic         v6_in_ready;
    logic         v6_in_mode = 1'b0;
    logic [191:0] v6_in_data = '0;
    logic [3:0]   v6_in_tag = '0;
    logic         v6_out_valid;
    logic         v6_out_ready = 1'b1;
    logic [191:0] v6_out_data;
    logic [3:0]   v6_out_tag;

    logic         v8_in_valid = 1'b0;
    logic         v8_in_ready;
    logic         v8_in_mode = 1'b0;
    logic [255:0] v8_in_data = '0;
    logic [3:0]   v8_in_tag = '0;
    logic         v8_out_valid;
    logic         v8_out_ready = 1'b1;
    logic [255:0] v8_out_data;
    logic [3:0]   v8_out_tag;

    int errors = 0;
    int checks = 0;
    logic [131:0] exp_q[$];

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(v6_in_valid), .in_ready(v6_in_ready), .in_mode(v6_in_mode),
        .in_data(v6_in_data), .in_tag(v6_in_tag),
        .out_valid(v6_out_valid), .out_ready(v6_out_ready),
        .out_data(v6_out_data), .out_tag(v6_out_tag)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_mode(v8_in_mode),
        .in_data(v8_in_data), .in_tag(v8_in_tag),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready),
        .out_data(v8_out_data), .out_tag(v8_out_tag)
    );

    // Reference: unpack into a 4 x nb byte matrix, rotate each row as a list, repack.
    function automatic logic [255:0] ref_shift(input logic [255:0] d, input bit inv, input int nb);
        logic [7:0]   st[4][8];
        logic [7:0]   row[8];
        int           off[4];
        logic [255:0] res;
        res = '0;
        off = '{0, 1, 2, 3};
        if (nb == 8) off = '{0, 1, 3, 4};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                st[r][c] = d[32*nb-1-8*(r+4*c) -: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) row[c] = st[r][c];
            for (int c = 0; c < nb; c++)
                st[r][c] = inv ? row[(c + nb - off[r]) % nb] : row[(c + off[r]) % nb];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < nb; c++)
                res[32*nb-1-8*(r+4*c) -: 8] = st[r][c];
        return res;
    endfunction

    function automatic logic [127:0] ref128(input logic [127:0] d, input bit inv);
        logic [255:0] full;
        full = ref_shift({128'b0, d}, inv, 4);
        return full[127:0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 128'h1234;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ignores_valid: out_valid=%b want 0", out_valid);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++;
        if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        step();
    endtask

    task automatic test_vectors_nb4();
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_tag = 4'd1;
        in_data = 128'h000102030405060708090a0b0c0d0e0f;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL nb4_latency: out_valid=%b want 1", out_valid); end
        checks++;
        if (out_data !== 128'h00050a0f04090e03080d02070c01060b) begin
            errors++; $display("FAIL nb4_fwd_seq: got %h want 00050a0f04090e03080d02070c01060b", out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL nb4_single_beat: out_valid=%b want 0", out_valid); end

        in_valid = 1'b1; in_mode = 1'b0; in_tag = 4'd3;
        in_data = 128'ha761ca9b97be8b45d8ad1a611fc97369;
        step();
        in_mode = 1'b1; in_tag = 4'd5;
        in_data = 128'ha7be1a6997ad739bd8c9ca451f618b61;
        checks++;
        if (out_data !== 128'ha7be1a6997ad739bd8c9ca451f618b61 || out_tag !== 4'd3) begin
            errors++; $display("FAIL nb4_fwd_aes: got %h/%0d want a7be1a6997ad739bd8c9ca451f618b61/3", out_data, out_tag);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'ha761ca9b97be8b45d8ad1a611fc97369 || out_tag !== 4'd5) begin
            errors++; $display("FAIL nb4_inv_aes: got v=%b %h/%0d want 1 a761ca9b97be8b45d8ad1a611fc97369/5", out_valid, out_data, out_tag);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_vectors_nb6_nb8();
        logic [191:0] orig6, fwd6;
        logic [255:0] orig8, fwd8;
        for (int k = 0; k < 24; k++) orig6[191-8*k -: 8] = 8'(k);
        for (int k = 0; k < 32; k++) orig8[255-8*k -: 8] = 8'(k);
        fwd6 = 192'h00050a0f04090e13080d12170c11160310150207_1401060b;
        fwd8 = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

        v6_in_valid = 1'b1; v6_in_mode = 1'b0; v6_in_data = orig6; v6_in_tag = 4'd6;
        v8_in_valid = 1'b1; v8_in_mode = 1'b0; v8_in_data = orig8; v8_in_tag = 4'd8;
        step();
        v6_in_mode = 1'b1; v6_in_data = fwd6; v6_in_tag = 4'd7;
        v8_in_mode = 1'b1; v8_in_data = fwd8; v8_in_tag = 4'd9;
        checks++;
        if (v6_out_valid !== 1'b1 || v6_out_data !== fwd6 || v6_out_tag !== 4'd6) begin
            errors++; $display("FAIL nb6_fwd: got v=%b %h/%0d want %h/6", v6_out_valid, v6_out_data, v6_out_tag, fwd6);
        end
        checks++;
        if (v8_out_valid !== 1'b1 || v8_out_data !== fwd8 || v8_out_tag !== 4'd8) begin
            errors++; $display("FAIL nb8_fwd: got v=%b %h/%0d want %h/8", v8_out_valid, v8_out_data, v8_out_tag, fwd8);
        end
        step();
        v6_in_valid = 1'b0;
        v8_in_valid = 1'b0;
        checks++;
        if (v6_out_data !== orig6 || v6_out_tag !== 4'd7) begin
            errors++; $display("FAIL nb6_inv: got %h/%0d want %h/7", v6_out_data, v6_out_tag, orig6);
        end
        checks++;
        if (v8_out_data !== orig8 || v8_out_tag !== 4'd9) begin
            errors++; $display("FAIL nb8_inv: got %h/%0d want %h/9", v8_out_data, v8_out_tag, orig8);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b, c;
        bit ma, mb, mc;
        a = rand128(); b = rand128(); c = rand128();
        ma = 1'b0; mb = 1'b1; mc = 1'($urandom_range(0, 1));
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = ma; in_data = a; in_tag = 4'hA;
        step();
        in_mode = mb; in_data = b; in_tag = 4'hB;
        checks++;
        if (out_valid !== 1'b1 || out_data !== ref128(a, ma) || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_a_in_out: got v=%b rdy=%b %h want 1 1 %h", out_valid, in_ready, out_data, ref128(a, ma));
        end
        step();
        in_mode = mc; in_data = c; in_tag = 4'hC;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: in_ready=%b want 0", in_ready); end
        step();
        checks++;
        if (in_ready !== 1'b0 || out_data !== ref128(a, ma) || out_tag !== 4'hA) begin
            errors++; $display("FAIL bp_hold: got rdy=%b %h/%h want 0 %h/a", in_ready, out_data, out_tag, ref128(a, ma));
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== ref128(b, mb) || out_tag !== 4'hB) begin
            errors++; $display("FAIL bp_b_out: got v=%b %h/%h want 1 %h/b", out_valid, out_data, out_tag, ref128(b, mb));
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== ref128(c, mc) || out_tag !== 4'hC) begin
            errors++; $display("FAIL bp_c_out: got v=%b %h/%h want 1 %h/c", out_valid, out_data, out_tag, ref128(c, mc));
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        bit acc;
        logic ir_before;
        logic [131:0] exp;
        exp_q.delete();
        in_valid = 1'b0;
        while (recv < 16 && cyc < 300) begin
            cyc++;
            if (!in_valid && sent < 16 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_mode  = 1'($urandom_range(0, 1));
                in_data  = rand128();
                in_tag   = 4'($urandom_range(0, 15));
            end
            ir_before = in_ready;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (in_ready !== ir_before) begin
                errors++; $display("FAIL stream_ready_comb: in_ready %b -> %b after out_ready change", ir_before, in_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_beat: got %h/%h want nothing", out_data, out_tag);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_tag, out_data} !== exp) begin
                        errors++; $display("FAIL stream_beat%0d: got %h/%h want %h/%h", recv, out_data, out_tag, exp[127:0], exp[131:128]);
                    end
                end
                recv++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back({in_tag, ref128(in_data, in_mode)});
                sent++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (recv != 16 || exp_q.size() != 0) begin
            errors++; $display("FAIL stream_count: received %0d left %0d want 16 and 0", recv, exp_q.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [127:0] z;
        z = rand128();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = rand128(); in_tag = 4'h1;
        step();
        in_data = rand128(); in_tag = 4'h2;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_full: rdy=%b v=%b want 0 1", in_ready, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 128'h0 || out_tag !== 4'h0) begin
            errors++; $display("FAIL rstmid_async: v=%b rdy=%b %h/%h want 0 1 0/0", out_valid, in_ready, out_data, out_tag);
        end
        step();
        #2;
        rst = 1'b0;
        in_valid = 1'b1; in_mode = 1'b1; in_data = z; in_tag = 4'h9;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== ref128(z, 1'b1) || out_tag !== 4'h9) begin
            errors++; $display("FAIL rstmid_after: v=%b %h/%h want 1 %h/9", out_valid, out_data, out_tag, ref128(z, 1'b1));
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_discard: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_vectors_nb4();
        test_vectors_nb6_nb8();
        test_backpressure();
        test_stream();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. It generalises the fixed 128-bit combinational ShiftRow to Rijndael block widths of 128, 192 and 256 bits, with a per-beat forward/inverse mode, sideband tag passthrough and a valid/ready stream interface. A 2-entry skid buffer registers both directions, so no combinational ready path is exposed. It sits between SubBytes and MixColumns in round pipelines.

Parameters:
NB, 4, state columns (32-bit words); legal values 4/6/8; any other value triggers `$fatal` at elaboration.
TAG_W, 4, sideband tag width (>=1), carried unchanged with data.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  stage can accept (registered).
in_mode  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled per beat.
in_data  in  32*NB  input state.
in_tag  in  TAG_W  sideband.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts.
out_data  out  32*NB  transformed state.
out_tag  out  TAG_W  tag of the beat on out_data.

Behaviour:
- Byte layout: byte k = in_data[32*NB-1-8k -: 8]; state s[r][c] = byte r+4c (column-major, MSB first).
- Row offsets: NB=4 or 6 -> {0,1,2,3}; NB=8 -> {0,1,3,4}.
- Forward: s'[r][c] = s[r][(c+off[r]) mod NB]. Inverse: s'[r][(c+off[r]) mod NB] = s[r][c]. Row 0 is always unchanged.
- Transform is applied combinationally at input. Transformed data and tag are stored; mode is not stored.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Storage: output register OUT plus skid register SKID. States:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE (load OUT).
  - ONE: out_valid=1, in_ready=1.
    - Accept & consume -> ONE (new beat into OUT).
    - Accept & ~consume -> FULL (beat into SKID).
    - ~Accept & consume -> EMPTY.
    - Neither -> hold.
  - FULL: out_valid=1, in_ready=0. Consume -> ONE (SKID moves to OUT). Otherwise hold. Input is ignored.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 beat/cycle while out_ready=1.
- Order preserved; no beat dropped or duplicated.
- OUT data and tag are stable while out_valid=1 and out_ready=0.
- Reset (async, any time including mid-stream): state EMPTY, out_valid=0, in_ready=1, out_data=0, out_tag=0, SKID cleared. In-flight beats are discarded.
- While rst=1, in_valid is ignored. The first accept is possible on the first rising edge after rst deasserts.
- Mode may change every beat. Different-mode beats in OUT and SKID are each transformed per their own mode.

Test Plan:
- NB=4, mode 0, data 000102030405060708090a0b0c0d0e0f, out_ready=1 -> one cycle later out_data 00050a0f04090e03080d02070c01060b, out_valid for exactly 1 cycle.
- NB=4, mode 0, a761ca9b97be8b45d8ad1a611fc97369 -> a7be1a6997ad739bd8c9ca451f618b61. Then mode 1 on that result -> a761ca9b97be8b45d8ad1a611fc97369. Tags 3 then 5 are returned in order.
- NB=6, mode 0, bytes 00..17 -> 00050a0f04090e13080d12170c11160310150207 1401060b (contiguous). NB=8, mode 0, bytes 00..1f -> 00050e13 0409121 7 080d161b 0c111a1f 10151e03 14190207 181d060b 1c010a0f (contiguous). Inverse of each -> original bytes.
- Backpressure: out_ready=0, push beats A, B, C back-to-back.
  - A lands in OUT, B in SKID, in_ready=0 the cycle after B is accepted, C is held.
  - Raise out_ready -> A, B, C emerge in order on consecutive cycles, none lost.
- Streaming: 16 random beats with random in_valid/out_ready, mixed modes, compared against a reference model -> exact match and order. in_ready is never combinationally dependent on out_ready.
- Reset mid-stream: assert rst asynchronously between clock edges while FULL -> out_valid=0, in_ready=1, out_data=0 immediately. A beat pushed after deassert emerges correctly with 1-cycle latency.
